// File: rtl/branch_flag_stage.sv
// Branch compare stage: computes rs1-rs2 condition flags and pc+imm target,
// registered behind a two-entry skid buffer with a registered in_ready_o.
module branch_flag_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2:0]      funct3_o,
  output logic            zero_flag_o,
  output logic            sign_flag_o,
  output logic            carry_flag_o,
  output logic            overflow_flag_o,
  output logic [XLEN-1:0] target_o
);

  typedef struct packed {
    logic [2:0]      funct3;
    logic            zero;
    logic            sign;
    logic            carry;
    logic            overflow;
    logic [XLEN-1:0] target;
  } beat_t;

  // EMPTY/ONE/FULL correspond to (main_v, skid_v) = 00/10/11.
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      state;
  beat_t       in_beat;
  beat_t       main_q;
  beat_t       skid_q;
  logic [XLEN:0] diff;
  logic        accept;
  logic        deliver;

  always_comb begin
    diff             = {1'b0, rs1_i} + {1'b0, ~rs2_i} + {{XLEN{1'b0}}, 1'b1};
    in_beat          = '0;
    in_beat.funct3   = funct3_i;
    in_beat.zero     = (diff[XLEN-1:0] == '0);
    in_beat.sign     = diff[XLEN-1];
    in_beat.carry    = ~diff[XLEN];
    in_beat.overflow = (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]) & (rs1_i[XLEN-1] ^ diff[XLEN-1]);
    in_beat.target   = pc_i + imm_i;
    accept           = in_valid_i & in_ready_o;
    deliver          = out_valid_o & out_ready_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else if (flush_i) begin
      // Payload is left as-is; only the valids are dropped.
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q      <= in_beat;
            state       <= ONE;
            out_valid_o <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_q <= in_beat;
          end else if (accept) begin
            skid_q     <= in_beat;
            state      <= FULL;
            in_ready_o <= 1'b0;
          end else if (deliver) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
          end
        end
        FULL: begin
          if (deliver) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

  assign funct3_o        = main_q.funct3;
  assign zero_flag_o     = main_q.zero;
  assign sign_flag_o     = main_q.sign;
  assign carry_flag_o    = main_q.carry;
  assign overflow_flag_o = main_q.overflow;
  assign target_o        = main_q.target;

endmodule
